// File: rtl/ntt_ctrl_pkg.sv
// Shared types for the NTT butterfly sequencer: FSM states, mode encoding,
// and a helper giving the start-to-done cycle count of one transform.
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Cycle (relative to the start cycle) on which done pulses.
    function automatic int ntt_total_cycles(int logn, int mem_lat, int btf_lat);
        return logn * ((1 << (logn - 1)) + mem_lat + btf_lat) + 1;
    endfunction

endpackage

// File: rtl/ntt_btf_ctrl_if.sv
// Command + memory/twiddle/butterfly control bundle of the NTT sequencer.
// master = sequencer side, slave = host/datapath side.
interface ntt_btf_ctrl_if #(
    parameter int LOGN = 8
);
    logic            start;
    logic            mode;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_a;
    logic [LOGN-1:0] rd_addr_b;
    logic [LOGN-1:0] w_addr;
    logic            w_inv;
    logic            btf_dif_dit;
    logic            btf_div_by_2;
    logic [1:0]      btf_opcode;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr_a;
    logic [LOGN-1:0] wr_addr_b;

    modport master (
        input  start, mode,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, w_addr, w_inv,
               btf_dif_dit, btf_div_by_2, btf_opcode, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, mode,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, w_addr, w_inv,
               btf_dif_dit, btf_div_by_2, btf_opcode, wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator: (stage, index, mode) -> (a, b, twiddle address).
// Forward and inverse share one datapath: inverse is forward with the stage mirrored.
module ntt_addr_gen
    import ntt_ctrl_pkg::*;
#(
    parameter int LOGN = 8,
    parameter int SW   = 3,
    parameter int JW   = 7
) (
    input  logic [SW-1:0]   i_s,
    input  logic [JW-1:0]   i_j,
    input  logic            i_mode,
    output logic [LOGN-1:0] o_a,
    output logic [LOGN-1:0] o_b,
    output logic [LOGN-1:0] o_w
);
    logic [SW-1:0]   w_sh;
    logic [LOGN-1:0] w_j, w_len, w_g, w_k;

    // w_sh = log2(len): LOGN-1-s forward, s inverse
    assign w_sh  = (i_mode == MODE_INV) ? i_s : SW'(LOGN-1) - i_s;
    assign w_j   = LOGN'(i_j);
    assign w_len = LOGN'(1) << w_sh;
    assign w_g   = w_j >> w_sh;
    assign w_k   = w_j & (w_len - LOGN'(1));
    // k < len and bit w_sh of a is clear, so OR stands in for the adds
    assign o_a   = ((w_g << w_sh) << 1) | w_k;
    assign o_b   = o_a | w_len;
    assign o_w   = (LOGN'(1) << (SW'(LOGN-1) - w_sh)) + w_g;
endmodule

// File: rtl/shiftreg.sv
// Fixed-depth delay line with asynchronous clear; output is input delayed DEPTH cycles.
module shiftreg #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [DEPTH-1:0][W-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/ntt_btf_ctrl.sv
// In-place NTT/INTT sequencer: issues N/2 butterflies per stage, then drains
// the memory+butterfly pipeline so the next stage never reads a stale coefficient.
module ntt_btf_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int LOGN    = 8,
    parameter int MEM_LAT = 1,
    parameter int BTF_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ntt_btf_ctrl_if.master bus
);
    localparam int L  = MEM_LAT + BTF_LAT;
    localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int JW = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int DW = $clog2(L + 1);
    localparam logic [JW-1:0] J_LAST = '1;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_s, w_s_nxt;
    logic [JW-1:0]   r_j, w_j_nxt;
    logic [DW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_mode, w_mode_nxt;
    logic            w_issue;
    logic [LOGN-1:0] w_a, w_b, w_w, w_ra, w_rb;
    logic [1:0]      w_ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_FWD;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_j     <= w_j_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_j_nxt     = r_j;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        case (r_state)
            S_IDLE: if (bus.start) begin
                w_mode_nxt  = bus.mode;
                w_s_nxt     = '0;
                w_j_nxt     = '0;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_j_nxt = r_j + JW'(1);
                if (r_j == J_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_cnt_nxt = r_cnt + DW'(1);
                // last drain cycle is the stage's final write
                if (r_cnt == DW'(L-1)) begin
                    if (r_s == SW'(LOGN-1)) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_s_nxt     = r_s + SW'(1);
                        w_j_nxt     = '0;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    ntt_addr_gen #(.LOGN(LOGN), .SW(SW), .JW(JW)) u_addr_gen (
        .i_s    (r_s),
        .i_j    (r_j),
        .i_mode (r_mode),
        .o_a    (w_a),
        .o_b    (w_b),
        .o_w    (w_w)
    );

    assign w_issue = (r_state == S_ISSUE);
    assign w_ra    = w_issue ? w_a : '0;
    assign w_rb    = w_issue ? w_b : '0;

    assign bus.rd_en      = w_issue;
    assign bus.rd_addr_a  = w_ra;
    assign bus.rd_addr_b  = w_rb;
    assign bus.w_addr     = w_issue ? w_w : '0;
    assign bus.w_inv      = r_mode;
    assign bus.busy       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign bus.done       = (r_state == S_FIN);
    assign bus.btf_opcode = 2'd0;

    // DIT for forward, DIF with halving for inverse; arrives with the operands
    shiftreg #(.W(2), .DEPTH(MEM_LAT)) u_ctl_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({w_issue & (r_mode == MODE_FWD), w_issue & (r_mode == MODE_INV)}),
        .o_q   (w_ctl)
    );
    assign bus.btf_dif_dit  = w_ctl[1];
    assign bus.btf_div_by_2 = w_ctl[0];

    shiftreg #(.W(1 + 2*LOGN), .DEPTH(L)) u_wr_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({w_issue, w_ra, w_rb}),
        .o_q   ({bus.wr_en, bus.wr_addr_a, bus.wr_addr_b})
    );
endmodule

// File: tb/tb_ntt_btf_ctrl.sv
// Directed bench for ntt_btf_ctrl at LOGN=3: address/timing tables, repeated
// start, mid-run reset, and a memory scoreboard against an in-order golden model.
module tb_ntt_btf_ctrl;
    import ntt_ctrl_pkg::*;

    localparam int LOGN = 3, MEM_LAT = 1, BTF_LAT = 4;
    localparam int L = MEM_LAT + BTF_LAT;
    localparam int STG = 4 + L;
    localparam int NCYC = 36;

    typedef struct { int a; int b; int w; } rdv_t;
    typedef struct packed {
        logic busy, done, rd, winv, dif, div;
        logic [1:0] op;
        logic wr;
        logic [2:0] a, b, w, wa, wb;
    } snap_t;
    typedef struct { logic [2:0] wa; logic [2:0] wb; logic [15:0] e; logic [15:0] o; } pend_t;

    logic clk = 1'b0;
    logic rst_n;
    ntt_btf_ctrl_if #(.LOGN(LOGN)) bus ();

    ntt_btf_ctrl #(.LOGN(LOGN), .MEM_LAT(MEM_LAT), .BTF_LAT(BTF_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tot = 0, n_pass = 0;
    rdv_t tbl [2][12];
    snap_t lg [NCYC];
    logic [15:0] mem [8];
    logic [15:0] gold [8];
    pend_t q [$];
    int hz_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.busy = bus.busy; s.done = bus.done; s.rd = bus.rd_en; s.winv = bus.w_inv;
        s.dif = bus.btf_dif_dit; s.div = bus.btf_div_by_2; s.op = bus.btf_opcode;
        s.wr = bus.wr_en; s.a = bus.rd_addr_a; s.b = bus.rd_addr_b; s.w = bus.w_addr;
        s.wa = bus.wr_addr_a; s.wb = bus.wr_addr_b;
        return s;
    endfunction

    function automatic bit in_win(int r);
        return (r >= 0) && (r / STG < 3) && (r % STG < 4);
    endfunction

    function automatic int win_idx(int r);
        return (r / STG) * 4 + r % STG;
    endfunction

    // Start on cycle 0 and log outputs of cycles 0..NCYC-1; rep adds ignored starts.
    task automatic run_log(input bit m, input bit rep);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            lg[c] = snap();
            start_drv((c == 0) || (rep && (c == 3 || c == 20)), (c == 0) ? m : ~m);
        end
        start_drv(1'b0, 1'b0);
    endtask

    task automatic start_drv(input bit s, input bit m);
        bus.start = s;
        bus.mode  = m;
    endtask

    task automatic check_run(input bit m, input string tag);
        int tdone;
        tdone = ntt_total_cycles(LOGN, MEM_LAT, BTF_LAT);
        for (int c = 0; c < NCYC; c++) begin
            snap_t sn;
            int rr, rw, rc;
            sn = lg[c]; rr = c - 1; rw = c - 1 - L; rc = c - 1 - MEM_LAT;
            chk($sformatf("%s rd_en@%0d", tag, c), 32'(sn.rd), 32'(in_win(rr)));
            if (in_win(rr)) begin
                chk($sformatf("%s rd_a@%0d", tag, c), 32'(sn.a), tbl[m][win_idx(rr)].a);
                chk($sformatf("%s rd_b@%0d", tag, c), 32'(sn.b), tbl[m][win_idx(rr)].b);
                chk($sformatf("%s w_addr@%0d", tag, c), 32'(sn.w), tbl[m][win_idx(rr)].w);
            end
            chk($sformatf("%s wr_en@%0d", tag, c), 32'(sn.wr), 32'(in_win(rw)));
            if (in_win(rw)) begin
                chk($sformatf("%s wr_a@%0d", tag, c), 32'(sn.wa), tbl[m][win_idx(rw)].a);
                chk($sformatf("%s wr_b@%0d", tag, c), 32'(sn.wb), tbl[m][win_idx(rw)].b);
            end
            chk($sformatf("%s dif_dit@%0d", tag, c), 32'(sn.dif), 32'(in_win(rc) && !m));
            chk($sformatf("%s div2@%0d", tag, c), 32'(sn.div), 32'(in_win(rc) && m));
            chk($sformatf("%s busy@%0d", tag, c), 32'(sn.busy), 32'(c >= 1 && c < tdone));
            chk($sformatf("%s done@%0d", tag, c), 32'(sn.done), 32'(c == tdone));
            chk($sformatf("%s opcode@%0d", tag, c), 32'(sn.op), 0);
            if (c >= 1) chk($sformatf("%s w_inv@%0d", tag, c), 32'(sn.winv), 32'(m));
        end
    endtask

    function automatic logic [15:0] tw(int w, bit inv);
        return inv ? 16'(2 * w + 3) : 16'(3 * w + 1);
    endfunction

    function automatic logic [31:0] bfly(logic [15:0] a, logic [15:0] b, logic [15:0] w, bit inv);
        logic [15:0] t, e, o;
        logic [16:0] s;
        if (!inv) begin
            t = 16'(b * w); e = a + t; o = a - t;
        end else begin
            s = {1'b0, a} + {1'b0, b}; e = s[16:1];
            t = a - b; o = 16'(t * w) >> 1;
        end
        return {e, o};
    endfunction

    // Sequential reference using the address formulas directly, no pipeline.
    task automatic golden(input bit inv);
        for (int s = 0; s < LOGN; s++) begin
            for (int j = 0; j < 4; j++) begin
                int len, g, k, a, b, w;
                logic [31:0] r;
                if (!inv) begin len = 8 >> (s + 1); g = j >> (2 - s); w = (1 << s) + g; end
                else begin len = 1 << s; g = j >> s; w = (8 >> (s + 1)) + g; end
                k = j & (len - 1); a = 2 * g * len + k; b = a + len;
                r = bfly(gold[a], gold[b], tw(w, inv), inv);
                gold[a] = r[31:16]; gold[b] = r[15:0];
            end
        end
    endtask

    // Memory + butterfly model: reads return pre-write contents, results land on wr_en.
    task automatic step_model();
        pend_t p;
        bit have;
        logic [31:0] r;
        logic [2:0] ra, rb;
        have = 0;
        if (bus.wr_en) begin
            if (q.size() == 0) hz_err++;
            else begin
                p = q.pop_front(); have = 1;
                if (p.wa != bus.wr_addr_a || p.wb != bus.wr_addr_b) hz_err++;
            end
        end
        if (bus.rd_en) begin
            ra = bus.rd_addr_a; rb = bus.rd_addr_b;
            foreach (q[i]) if (q[i].wa == ra || q[i].wb == ra || q[i].wa == rb || q[i].wb == rb) hz_err++;
            if (have && (p.wa == ra || p.wb == ra || p.wa == rb || p.wb == rb)) hz_err++;
            r = bfly(mem[ra], mem[rb], tw(int'(bus.w_addr), bus.w_inv), bus.w_inv);
            q.push_back('{wa: ra, wb: rb, e: r[31:16], o: r[15:0]});
        end
        if (have) begin mem[p.wa] = p.e; mem[p.wb] = p.o; end
    endtask

    task automatic hz_run(input bit m, input string tag);
        bit seen;
        for (int i = 0; i < 8; i++) begin mem[i] = 16'($urandom); gold[i] = mem[i]; end
        q.delete(); hz_err = 0; seen = 0;
        @(negedge clk); start_drv(1'b1, m);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); start_drv(1'b0, 1'b0);
            step_model();
            if (bus.done) begin seen = 1; break; end
        end
        chk({tag, " done_seen"}, 32'(seen), 1);
        golden(m);
        chk({tag, " hazards"}, 32'(hz_err), 0);
        chk({tag, " queue_empty"}, 32'(q.size()), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("%s mem[%0d]", tag, i), 32'(mem[i]), 32'(gold[i]));
    endtask

    initial begin
        rst_n = 1'b0;
        start_drv(1'b0, 1'b0);
        tbl[0] = '{'{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1}, '{0,2,2}, '{1,3,2},
                   '{4,6,3}, '{5,7,3}, '{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}};
        tbl[1] = '{'{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}, '{0,2,2}, '{1,3,2},
                   '{4,6,3}, '{5,7,3}, '{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1}};

        repeat (2) @(negedge clk);
        chk("reset_state", 32'(snap()), 0);
        rst_n = 1'b1;

        run_log(1'b0, 1'b0); check_run(1'b0, "fwd");
        run_log(1'b1, 1'b0); check_run(1'b1, "inv");
        run_log(1'b0, 1'b1); check_run(1'b0, "rep");

        // abort in stage 2 with two butterflies still in flight
        @(negedge clk); start_drv(1'b1, 1'b0);
        @(negedge clk); start_drv(1'b0, 1'b0);
        repeat (11) @(negedge clk);
        chk("pre_rst busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 32'(snap()), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_quiet@%0d", c), 32'({bus.rd_en, bus.wr_en, bus.busy, bus.done}), 0);
        end
        run_log(1'b0, 1'b0); check_run(1'b0, "after_rst");

        hz_run(1'b0, "hz_fwd");
        hz_run(1'b1, "hz_inv");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/ntt_btf_ctrl.md
Name: ntt_btf_ctrl

Overview:
Sequencer that runs one complete in-place forward NTT or inverse NTT by driving a single unified butterfly unit and a dual-port coefficient memory.
- Forward: DIT/Cooley-Tukey. Inverse: DIF/Gentleman-Sande with divide-by-2 on every stage.
- Each stage issues one butterfly per cycle: read addresses, twiddle address and butterfly control.
- Between stages it waits for the pipeline to drain, so the next stage never reads a stale coefficient.
- Sits between the top-level command interface and the memory/twiddle-ROM/butterfly datapath.

Parameters:
LOGN, 8, log2 of polynomial length N; N/2 butterflies per stage, LOGN stages.
MEM_LAT, 1, read latency of coefficient RAM and twiddle ROM, in cycles.
BTF_LAT, 4, total butterfly latency a/b/w in to e/o out, including the div-by-2 register.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse to begin a transform; ignored while busy
mode  in  1  0: forward NTT, 1: inverse NTT; sampled with start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the final write has been issued
rd_en  out  1  coefficient read strobe
rd_addr_a  out  LOGN  address of butterfly input a
rd_addr_b  out  LOGN  address of butterfly input b
w_addr  out  LOGN  twiddle ROM address, valid with rd_en
w_inv  out  1  selects inverse twiddle table (= latched mode)
btf_dif_dit  out  1  butterfly dif_dit, aligned to butterfly inputs
btf_div_by_2  out  1  butterfly div_by_2, aligned to butterfly inputs
btf_opcode  out  2  constant 2'd0 (butterfly)
wr_en  out  1  coefficient write strobe, aligned to e/o outputs
wr_addr_a  out  LOGN  write address for e
wr_addr_b  out  LOGN  write address for o

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; stage, index and drain counters to 0; all delay lines cleared. Every output reads 0 except btf_opcode, which is always 0. Reset mid-transform aborts it: in-flight writes are squashed and no done pulse is produced.
- FSM IDLE:
  - start=1 latches mode and sets s=0, j=0. Go to ISSUE.
  - busy rises on the next cycle.
- FSM ISSUE (one butterfly per cycle, j = 0..N/2-1):
  - rd_en=1 on every ISSUE cycle. rd_en is combinational on state; no gaps.
  - Forward: len = N>>(s+1); g = j>>(LOGN-1-s); k = j&(len-1); a = 2*g*len + k; b = a + len; w_addr = (1<<s) + g.
  - Inverse: len = 1<<s; g = j>>s; k = j&(len-1); a = 2*g*len + k; b = a + len; w_addr = (N>>(s+1)) + g.
  - When j = N/2-1: go to DRAIN and clear the drain counter.
- FSM DRAIN:
  - Lasts exactly L = MEM_LAT + BTF_LAT cycles; rd_en=0.
  - The last cycle of DRAIN coincides with the final wr_en of the stage.
  - Then, if s = LOGN-1, go to FIN; otherwise s++, j=0 and go to ISSUE.
- FSM FIN: done=1 for one cycle, busy=0, go to IDLE. A start in FIN is ignored.
- Delay lines:
  - btf_dif_dit (= ~mode, since 1 means DIT) and btf_div_by_2 (= mode) are rd_en-qualified, delayed MEM_LAT cycles, and 0 when not valid.
  - wr_en, wr_addr_a and wr_addr_b are rd_en/rd_addr delayed by L cycles.
- Timing:
  - Each stage takes N/2 + L cycles; stages are back-to-back.
  - start at cycle 0 → first rd_en at cycle 1 → done at cycle LOGN*(N/2+L)+1.
- Hazard rule: the next stage's first read occurs only after the current stage's last write cycle. Required because reads in stage s+1 depend on writes from stage s.
- Widths: all address arithmetic is LOGN bits; the maximum w_addr is N-1, so no overflow. Counters: s is ceil(log2 LOGN) bits, j is LOGN-1 bits, drain counter is ceil(log2(L+1)) bits.

Decomposition:
- Shared package ntt_ctrl_pkg: state enum (IDLE, ISSUE, DRAIN, FIN), mode encoding constants, and a function computing total cycle count for the bench.
- One sub-module, ntt_addr_gen: combinational (s, j, mode) → (a, b, w_addr).
- Delay lines reuse the existing shiftreg module.

Test Plan (LOGN=3, MEM_LAT=1, BTF_LAT=4, so L=5):
- Forward start: reads (0,4),(1,5),(2,6),(3,7) with w=1,1,1,1; then (0,2)w2,(1,3)w2,(4,6)w3,(5,7)w3; then (0,1)w4,(2,3)w5,(4,5)w6,(6,7)w7. btf_dif_dit=1 and btf_div_by_2=0.
- Inverse start: reads (0,1)w4,(2,3)w5,(4,5)w6,(6,7)w7; then (0,2)w2,(1,3)w2,(4,6)w3,(5,7)w3; then (0,4)…(3,7) w1. btf_dif_dit=0, btf_div_by_2=1, w_inv=1.
- Timing: start at cycle 0 → rd_en cycles 1-4, 10-13, 19-22; wr_en cycles 6-9, 15-18, 24-27; done at cycle 28; busy high for cycles 1-27.
- Repeated start during busy (cycles 3 and 20) → no effect; sequence and done timing identical to the forward case.
- rst_n low at cycle 12 → all outputs 0 immediately; no wr_en afterwards, no done; a new start then runs a clean forward transform.
- Hazard check with a scoreboard memory model and random coefficients: transform result matches the golden model. No read of an address occurs while a pending write to it is still in flight.
